// File: rtl/cell_edit_writer.sv
// ============================================================================
//  Module      : cell_edit_writer
//  Description : Edit-mode write side of the cell map. Owns the cursor and
//                runs single-cell read-modify-write toggles and, optionally,
//                a full-map clear sweep on the map memory port.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MAP_WIDTH   map columns, 1..255
//    MAP_HEIGHT  map rows,    1..255
//
//  Ports
//    clk                      rising-edge clock
//    rst                      asynchronous reset, active low
//    mode                     commands accepted only when == `MODE_EDIT
//    btn_up/down/left/right   one-cycle cursor move pulses
//    btn_toggle               one-cycle pulse: invert the cell under cursor
//    btn_clear                one-cycle pulse: write 0 to every cell
//    cur_x, cur_y             cursor position (read by the display path)
//    mem_req, mem_we          memory request / write enable (registered)
//    mem_x, mem_y, mem_wdata  memory address and write data (registered)
//    mem_rdata                read data, valid with mem_ack on a read
//    mem_ack                  memory accepts/completes the current request
//    busy                     high whenever an operation is in progress
//    done                     one-cycle pulse when a toggle or clear ends
//
//  Build options
//    CELL_EDIT_CLEAR_EN  when defined, the clear sweep is built; otherwise
//                        btn_clear is ignored and toggle has top priority.
// ============================================================================

`default_nettype none

`ifndef MODE_EDIT
`define MODE_EDIT 1'b1
`endif

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

module cell_edit_writer #(
    parameter int MAP_WIDTH  = 8,
    parameter int MAP_HEIGHT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic                   btn_up,
    input  logic                   btn_down,
    input  logic                   btn_left,
    input  logic                   btn_right,
    input  logic                   btn_toggle,
    input  logic                   btn_clear,
    output logic [`ADDR_WIDTH-1:0] cur_x,
    output logic [`ADDR_WIDTH-1:0] cur_y,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [`ADDR_WIDTH-1:0] mem_x,
    output logic [`ADDR_WIDTH-1:0] mem_y,
    output logic                   mem_wdata,
    input  logic                   mem_rdata,
    input  logic                   mem_ack,
    output logic                   busy,
    output logic                   done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Last legal coordinate on each axis, held at the address width so the
    // wrap comparisons never overflow (a 255-wide map still fits).
    localparam logic [`ADDR_WIDTH-1:0] c_X_MAX  = `ADDR_WIDTH'(MAP_WIDTH - 1);
    localparam logic [`ADDR_WIDTH-1:0] c_Y_MAX  = `ADDR_WIDTH'(MAP_HEIGHT - 1);
    localparam logic [`ADDR_WIDTH-1:0] c_ZERO   = '0;
    localparam logic [`ADDR_WIDTH-1:0] c_ONE    = `ADDR_WIDTH'(1);

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_CLR  = 2'd3
    } state_t;

    state_t                   r_state;

    // ------------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------------
    logic [`ADDR_WIDTH-1:0]   r_cur_x;
    logic [`ADDR_WIDTH-1:0]   r_cur_y;
    logic                     r_mem_req;
    logic                     r_mem_we;
    logic [`ADDR_WIDTH-1:0]   r_mem_x;
    logic [`ADDR_WIDTH-1:0]   r_mem_y;
    logic                     r_mem_wdata;
    logic                     r_done;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                     w_edit;
    logic [`ADDR_WIDTH-1:0]   w_cur_x_next;
    logic [`ADDR_WIDTH-1:0]   w_cur_y_next;

    assign w_edit = (mode == `MODE_EDIT);

    // Next cursor position for a move request. Up beats down and left beats
    // right; both axes update together. Up/left decrement, wrapping at zero.
    always_comb begin
        w_cur_x_next = r_cur_x;
        w_cur_y_next = r_cur_y;

        if (btn_up) begin
            w_cur_y_next = (r_cur_y == c_ZERO) ? c_Y_MAX : (r_cur_y - c_ONE);
        end else if (btn_down) begin
            w_cur_y_next = (r_cur_y >= c_Y_MAX) ? c_ZERO : (r_cur_y + c_ONE);
        end

        if (btn_left) begin
            w_cur_x_next = (r_cur_x == c_ZERO) ? c_X_MAX : (r_cur_x - c_ONE);
        end else if (btn_right) begin
            w_cur_x_next = (r_cur_x >= c_X_MAX) ? c_ZERO : (r_cur_x + c_ONE);
        end
    end

`ifdef CELL_EDIT_CLEAR_EN
    // Sweep position flags: the write address itself is the sweep counter.
    logic                     w_clr_last_col;
    logic                     w_clr_last_row;

    assign w_clr_last_col = (r_mem_x >= c_X_MAX);
    assign w_clr_last_row = (r_mem_y >= c_Y_MAX);
`else
    // Clear button has no function in this build.
    logic                     w_unused_clear;

    assign w_unused_clear = btn_clear;
`endif

    // ------------------------------------------------------------------------
    // Main sequencer
    // ------------------------------------------------------------------------
    // All memory-side outputs are registered and only change on an accepted
    // transfer (mem_ack while mem_req is high), so they stay stable through
    // any number of wait cycles. Once an operation starts it ignores mode and
    // every button until it completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cur_x     <= c_ZERO;
            r_cur_y     <= c_ZERO;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_x     <= c_ZERO;
            r_mem_y     <= c_ZERO;
            r_mem_wdata <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_edit) begin
`ifdef CELL_EDIT_CLEAR_EN
                        if (btn_clear) begin
                            // Raster sweep starts at the origin writing zeros.
                            r_state     <= S_CLR;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= 1'b1;
                            r_mem_wdata <= 1'b0;
                            r_mem_x     <= c_ZERO;
                            r_mem_y     <= c_ZERO;
                        end else
`endif
                        if (btn_toggle) begin
                            // The cursor is frozen while busy, so latching it
                            // here fixes the address for both phases.
                            r_state   <= S_RD;
                            r_mem_req <= 1'b1;
                            r_mem_we  <= 1'b0;
                            r_mem_x   <= r_cur_x;
                            r_mem_y   <= r_cur_y;
                        end else begin
                            r_cur_x <= w_cur_x_next;
                            r_cur_y <= w_cur_y_next;
                        end
                    end
                end

                S_RD: begin
                    if (mem_ack) begin
                        // Read completes: turn the same request into a write
                        // of the inverted cell value.
                        r_mem_wdata <= ~mem_rdata;
                        r_mem_we    <= 1'b1;
                        r_state     <= S_WR;
                    end
                end

                S_WR: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end

`ifdef CELL_EDIT_CLEAR_EN
                S_CLR: begin
                    if (mem_ack) begin
                        // mem_req stays high between sweep writes; only the
                        // address moves after each accepted write.
                        if (w_clr_last_col) begin
                            r_mem_x <= c_ZERO;
                            if (w_clr_last_row) begin
                                r_mem_req <= 1'b0;
                                r_mem_we  <= 1'b0;
                                r_mem_y   <= c_ZERO;
                                r_done    <= 1'b1;
                                r_state   <= S_IDLE;
                            end else begin
                                r_mem_y <= r_mem_y + c_ONE;
                            end
                        end else begin
                            r_mem_x <= r_mem_x + c_ONE;
                        end
                    end
                end
`endif

                default: begin
                    // Unreachable encodings fall back to a quiet idle.
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign cur_x     = r_cur_x;
    assign cur_y     = r_cur_y;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_x     = r_mem_x;
    assign mem_y     = r_mem_y;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_cell_edit_writer.sv
// ============================================================================
//  Module      : tb_cell_edit_writer
//  Description : Self-checking bench for cell_edit_writer. A memory responder
//                logs every accepted transfer; an abstract model predicts the
//                transfer list, cursor and done count for each command.
//  Revision    : 1.0  initial release
// ============================================================================

`default_nettype none

module tb_cell_edit_writer;

    localparam int W = 8;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       btn_up, btn_down, btn_left, btn_right, btn_toggle, btn_clear;
    logic [7:0] cur_x, cur_y, mem_x, mem_y;
    logic       mem_req, mem_we, mem_wdata, mem_rdata, busy, done;
    logic       mem_ack = 1'b0;

    int         checks = 0;
    int         errors = 0;

    // Memory contents (written only by the main sequence, from the log).
    logic       tb_mem [0:H-1][0:W-1];
    int         ack_mode = 0;      // 0 tied high, 1 random, 2 manual
    logic       ack_manual = 1'b0;
    logic [17:0] log_q[$];         // {we, x, y, wdata(0 for reads)}
    logic [17:0] exp_q[$];
    int          cx = 0;
    int          cy = 0;

    always #5 clk = ~clk;

    cell_edit_writer #(.MAP_WIDTH(W), .MAP_HEIGHT(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_toggle (btn_toggle),
        .btn_clear  (btn_clear),
        .cur_x      (cur_x),
        .cur_y      (cur_y),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_x      (mem_x),
        .mem_y      (mem_y),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .busy       (busy),
        .done       (done)
    );

    assign mem_rdata = tb_mem[mem_y[2:0]][mem_x[2:0]];

    // Memory responder: chooses ack for the coming edge, logs the transfer.
    always @(negedge clk) begin
        #1;
        case (ack_mode)
            0:       mem_ack = 1'b1;
            1:       mem_ack = 1'($urandom_range(0, 1));
            default: mem_ack = ack_manual;
        endcase
        #1;
        if (rst && mem_req && mem_ack)
            log_q.push_back({mem_we, mem_x, mem_y, mem_we ? mem_wdata : 1'b0});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // b = {clear, toggle, up, down, left, right}
    task automatic pulse(input logic [5:0] b);
        @(negedge clk);
        {btn_clear, btn_toggle, btn_up, btn_down, btn_left, btn_right} = b;
        @(negedge clk);
        {btn_clear, btn_toggle, btn_up, btn_down, btn_left, btn_right} = 6'b0;
    endtask

    // Reference model: expected transfers and cursor after a command.
    task automatic build_exp(input logic [5:0] b, input logic m);
        exp_q.delete();
        if (!m) return;
`ifdef CELL_EDIT_CLEAR_EN
        if (b[5]) begin
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    exp_q.push_back({1'b1, 8'(x), 8'(y), 1'b0});
            return;
        end
`endif
        if (b[4]) begin
            exp_q.push_back({1'b0, 8'(cx), 8'(cy), 1'b0});
            exp_q.push_back({1'b1, 8'(cx), 8'(cy), ~tb_mem[cy][cx]});
            return;
        end
        if (b[3])      cy = (cy + H - 1) % H;
        else if (b[2]) cy = (cy + 1) % H;
        if (b[1])      cx = (cx + W - 1) % W;
        else if (b[0]) cx = (cx + 1) % W;
    endtask

    // Wait for busy to drop; checks the request holds steady while unacked.
    task automatic wait_done(input int drop_at, output int n, output int dcnt);
        logic [17:0] snap;
        logic        snap_req, snap_ack;
        #3;
        snap     = {mem_we, mem_x, mem_y, mem_wdata};
        snap_req = mem_req;
        snap_ack = mem_ack;
        n        = 0;
        dcnt     = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            #3;
            n++;
            if (done) dcnt++;
            if (n == drop_at) mode = 1'b0;
            if (snap_req && !snap_ack) begin
                chk("hold_req", mem_req, 1);
                chk("hold_bus", {mem_we, mem_x, mem_y, mem_wdata}, snap);
            end
            snap     = {mem_we, mem_x, mem_y, mem_wdata};
            snap_req = mem_req;
            snap_ack = mem_ack;
        end
        chk("timeout", busy, 0);
    endtask

    task automatic finish_op(input int n, input int dcnt, input bit chk_busy);
        bit op;
        op = (exp_q.size() != 0);
        chk("log_len", log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk("log_entry", log_q[i], exp_q[i]);
        chk("done_cnt", dcnt, op);
        if (chk_busy) chk("busy_cycles", n, exp_q.size());
        chk("cur_x", cur_x, cx);
        chk("cur_y", cur_y, cy);
        foreach (log_q[i])
            if (log_q[i][17]) tb_mem[log_q[i][8:1]][log_q[i][16:9]] = log_q[i][0];
        log_q.delete();
        if (op) begin
            @(negedge clk);
            chk("done_width", done, 0);
        end
    endtask

    task automatic step(input logic [5:0] b, input logic m, input int am, input int drop_at);
        int n, dcnt;
        mode     = m;
        ack_mode = am;
        build_exp(b, m);
        pulse(b);
        wait_done(drop_at, n, dcnt);
        finish_op(n, dcnt, am == 0);
        mode = 1'b1;
    endtask

    task automatic fill(input logic v);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                tb_mem[y][x] = v;
    endtask

    function automatic int count_ones();
        int s = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                s += int'(tb_mem[y][x]);
        return s;
    endfunction

    initial begin
        logic [5:0] b;
        int         r;
        rst  = 1'b0;
        mode = 1'b0;
        {btn_clear, btn_toggle, btn_up, btn_down, btn_left, btn_right} = 6'b0;
        fill(1'b0);

        // Reset state (ack tied high must not provoke anything)
        repeat (3) @(negedge clk);
        chk("rst_cur_x", cur_x, 0);
        chk("rst_cur_y", cur_y, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", {mem_x, mem_y}, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_req", mem_req, 0);
        mode = 1'b1;

        // Moves and wrap
        step(6'b000010, 1'b1, 0, -1);
        chk("left_wrap", cur_x, 7);
        step(6'b001101, 1'b1, 0, -1);
        chk("right_wrap", cur_x, 0);
        chk("up_wins_wrap", cur_y, 7);
        repeat (3) step(6'b000001, 1'b1, 0, -1);
        repeat (2) step(6'b001000, 1'b1, 0, -1);
        chk("at_3", cur_x, 3);
        chk("at_5", cur_y, 5);

        // Toggle, zero-wait, cycle-exact
        begin
            int n0;
            ack_mode = 0;
            build_exp(6'b010000, 1'b1);
            pulse(6'b010000);
            chk("t_rd_req", {mem_req, mem_we, busy}, 3'b101);
            chk("t_rd_addr", {mem_x, mem_y}, {8'd3, 8'd5});
            @(negedge clk);
            chk("t_wr", {mem_req, mem_we, mem_wdata, busy}, 4'b1111);
            chk("t_wr_addr", {mem_x, mem_y}, {8'd3, 8'd5});
            @(negedge clk);
            chk("t_end", {mem_req, busy, done}, 3'b001);
            #3;
            n0 = 2;
            finish_op(n0, int'(done), 1'b1);
        end
        chk("cell_set", tb_mem[5][3], 1);
        step(6'b010000, 1'b1, 0, -1);
        chk("cell_clr", tb_mem[5][3], 0);

        // Toggle with wait states; move during busy is dropped
        begin
            int n, dcnt;
            ack_mode   = 2;
            ack_manual = 1'b0;
            build_exp(6'b010000, 1'b1);
            pulse(6'b010000);
            for (int i = 0; i < 4; i++) begin
                chk("wait_rd", {mem_req, mem_we, mem_x, mem_y}, {2'b10, 8'd3, 8'd5});
                btn_right = (i == 0);
                @(negedge clk);
            end
            btn_right = 1'b0;
            chk("no_early_write", log_q.size(), 0);
            ack_mode = 0;
            wait_done(-1, n, dcnt);
            finish_op(n, dcnt, 1'b0);
            chk("cursor_frozen", cur_x, 3);
        end

        // Not in edit mode: toggle ignored
        step(6'b010000, 1'b0, 0, -1);

        // Clear sweep (or ignored clear)
        fill(1'b1);
        step(6'b100000, 1'b1, 0, -1);
`ifdef CELL_EDIT_CLEAR_EN
        chk("cleared", count_ones(), 0);
`else
        chk("clear_ignored", count_ones(), W * H);
`endif

        // Clear+toggle together, mode leaves edit mid-operation
        fill(1'b1);
        step(6'b110000, 1'b1, 0, 10);
`ifdef CELL_EDIT_CLEAR_EN
        chk("prio_clear", count_ones(), 0);
`else
        chk("prio_toggle", count_ones(), W * H - 1);
`endif

        // Asynchronous reset during the write phase
        step(6'b000101, 1'b1, 0, -1);
        ack_mode   = 2;
        ack_manual = 1'b0;
        pulse(6'b010000);
        ack_manual = 1'b1;
        @(negedge clk);
        ack_manual = 1'b0;
        chk("in_wr", {mem_req, mem_we}, 2'b11);
        #3 rst = 1'b0;
        #1;
        chk("arst_req", mem_req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cur", {cur_x, cur_y}, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        ack_mode = 0;
        log_q.delete();
        cx = 0;
        cy = 0;
        @(negedge clk);

        // Randomized commands against the model
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                tb_mem[y][x] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 15);
            if (r < 8)       b = {2'b00, 4'($urandom_range(0, 15))};
            else if (r < 14) b = {2'b01, 4'($urandom_range(0, 15))};
            else             b = {1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
            step(b, 1'($urandom_range(0, 7) != 0), $urandom_range(0, 1), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cell_edit_writer.md
# cell_edit_writer

Write-side counterpart of the display path. In edit mode it owns the cursor position and performs single-cell read-modify-write toggles and full-map clears on the cell map memory. The display controller reads cells from that memory and `cur_x`/`cur_y` from this block. Sits between the button-pulse front end and the map memory write port.

## Interface
Parameters:
- `MAP_WIDTH`, 8: map columns; legal range 1..255.
- `MAP_HEIGHT`, 8: map rows; legal range 1..255.

Ports:
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: reset, asynchronous, active-low.
- `mode` input 1: compared against `` `MODE_EDIT ``; commands are accepted only when equal.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` input 1 each: one-cycle move pulses.
- `btn_toggle` input 1: one-cycle pulse; invert the cell under the cursor.
- `btn_clear` input 1: one-cycle pulse; write 0 to every cell.
- `cur_x`, `cur_y` output `` `ADDR_WIDTH `` (8): cursor position.
- `mem_req` output 1: memory request.
- `mem_we` output 1: 1 = write, 0 = read.
- `mem_x`, `mem_y` output `` `ADDR_WIDTH ``: cell address.
- `mem_wdata` output 1: write data.
- `mem_rdata` input 1: read data; valid in the cycle `mem_ack` = 1 for a read.
- `mem_ack` input 1: memory accepts or completes the request.
- `busy` output 1: high whenever the state is not IDLE.
- `done` output 1: one-cycle pulse when a toggle or clear finishes.

## Operation
- State machine states: IDLE, RD, WR, CLR.
- **IDLE:**
  - Accept commands only when `mode` == `` `MODE_EDIT ``.
  - Priority: clear > toggle > moves.
  - Pulses that arrive outside IDLE or outside edit mode are dropped, not queued.
- **Moves:**
  - Horizontal and vertical moves apply in the same cycle.
  - `up` beats `down`; `left` beats `right`.
  - `left` at x=0 wraps to `MAP_WIDTH-1`; `right` at `MAP_WIDTH-1` wraps to 0.
  - y wraps the same way against `MAP_HEIGHT`.
  - Moves never touch the memory interface.
- **Toggle:**
  - IDLE→RD: `mem_req`=1, `mem_we`=0, address = cursor.
  - RD, on `mem_ack`: capture `~mem_rdata` into `mem_wdata` and go to WR, with `mem_we`=1 and the same address.
  - WR, on `mem_ack`: go to IDLE and pulse `done`.
- **Clear:**
  - IDLE→CLR with the address at (0,0), `mem_we`=1, `mem_wdata`=0.
  - On each `mem_ack`, advance x. When x wraps, advance y.
  - The ack at (`MAP_WIDTH-1`, `MAP_HEIGHT-1`) ends the sweep: go to IDLE and pulse `done`.
  - Exactly `MAP_WIDTH*MAP_HEIGHT` writes are issued.
- **Handshake:**
  - `mem_req`, `mem_we`, `mem_x`, `mem_y`, `mem_wdata` are registered.
  - They hold stable while `mem_req`=1 and `mem_ack`=0.
  - `mem_ack` is ignored when `mem_req`=0.
  - Between consecutive clear writes, `mem_req` stays high and only the address changes after each ack.
- **Mode change:** if `mode` leaves edit while busy, the operation still runs to completion; the handshake is never abandoned.
- **Cursor during operations:** the cursor is frozen while busy. The toggle address is the cursor value latched at acceptance.
- **Address width:** x and y are held in 8 bits; compare against `MAP_WIDTH-1` and `MAP_HEIGHT-1` with no overflow.

## Timing
- Reset values: `cur_x`=0, `cur_y`=0, `mem_req`=0, `mem_we`=0, `mem_x`=0, `mem_y`=0, `mem_wdata`=0, `busy`=0, `done`=0, state IDLE.
- Reset is asynchronous and takes effect mid-operation; `mem_req` drops immediately.
- Command pulse sampled at edge N: `mem_req`/`busy` high from N+1.
- Move sampled at edge N: new `cur_x`/`cur_y` visible after N+1 (one-cycle latency).
- Toggle with zero-wait memory (ack in the same cycle as req):
  - read in cycle N+1, write in N+2;
  - `busy` falls and `done` pulses in N+3;
  - a new command is accepted at edge N+3.
- Each wait cycle (`mem_ack`=0) extends the current phase by exactly one cycle.
- Clear with zero-wait memory: `busy` lasts `MAP_WIDTH*MAP_HEIGHT` cycles; `done` pulses in the following cycle.

## Configuration
- Macro: `CELL_EDIT_CLEAR_EN`.
- Defined: the CLR state and clear sweep exist as described.
- Undefined:
  - CLR is not built and `btn_clear` is ignored.
  - Toggle then has top priority over moves.
  - All other behaviour is identical.

## Test plan
- **Reset/moves:** reset, then `mode`=EDIT, `btn_left` once → `cur_x`=7; `btn_up`+`btn_down`+`btn_right` in one pulse → `cur_x`=0, `cur_y`=7.
- **Toggle, zero-wait:** cursor (3,5), cell=0, ack tied high → read (3,5), then write (3,5) with `wdata`=1; `done` at N+3; the cell reads 1. A second toggle writes 0.
- **Toggle with waits:** hold `mem_ack`=0 for 4 cycles in RD → address/`we` stable throughout, no write issued early; `btn_right` during busy does not move the cursor.
- **Clear:** preload all ones, pulse `btn_clear` → 64 writes of 0 in raster order (0,0)…(7,7); `done` once; all cells 0. Repeat with the macro undefined → no memory activity.
- **Mode/priority:** `mode`≠EDIT plus `btn_toggle` → no request. Enter edit mode, then `btn_clear`+`btn_toggle` together → clear runs. Leave edit mid-clear → the sweep still finishes.
- **Reset mid-operation:** assert `rst` low during WR → `mem_req`=0, `cur_x`=`cur_y`=0, `busy`=0 without waiting for a clock edge.
